// File: rtl/common_types_pkg.sv
// common_types_pkg: shared widths, word type and multiplier FSM state encoding
package common_types_pkg;

    localparam int MULT_WORD_W = 32;
    localparam int MULT_BPC    = 1;
    localparam int MULT_ITER   = MULT_WORD_W / MULT_BPC;

    typedef logic [MULT_WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mult_state_t;

endpackage

// File: rtl/mult_sequencer_step.sv
// mult_step: one shift-add iteration, adds |a| * chunk aligned at shift_i into the accumulator
module mult_step #(
    parameter int WORD_W         = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int SH_W           = 6
) (
    input  logic [2*WORD_W-1:0]       acc_i,
    input  logic [WORD_W-1:0]         a_i,
    input  logic [BITS_PER_CYCLE-1:0] chunk_i,
    input  logic [SH_W-1:0]           shift_i,
    output logic [2*WORD_W-1:0]       acc_o
);

    logic [2*WORD_W-1:0] partial;

    // Widen both factors to the accumulator width so the partial product never truncates
    always_comb begin
        partial = ({{WORD_W{1'b0}}, a_i} * {{(2*WORD_W-BITS_PER_CYCLE){1'b0}}, chunk_i}) << shift_i;
        acc_o   = acc_i + partial;
    end

endmodule

// File: rtl/mult_sequencer.sv
// mult_sequencer: iterative shift-add multiplier with sequencing FSM for MUL/MULH/MULHSU/MULHU
module mult_sequencer
    import common_types_pkg::*;
#(
    parameter int WORD_W         = MULT_WORD_W,
    parameter int BITS_PER_CYCLE = MULT_BPC
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              start,
    input  logic              flush,
    input  logic [WORD_W-1:0] opa,
    input  logic [WORD_W-1:0] opb,
    input  logic              mult_half,
    input  logic              signed_a,
    input  logic              signed_b,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] result
);

    localparam int ITER = WORD_W / BITS_PER_CYCLE;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int SW   = $clog2(2 * WORD_W);
    localparam int MSB  = WORD_W - 1;

    mult_state_t         state_q, state_d;
    logic [WORD_W-1:0]   a_q, a_d;
    logic [WORD_W-1:0]   b_q, b_d;
    logic                neg_q, neg_d;
    logic                half_q, half_d;
    logic [2*WORD_W-1:0] acc_q, acc_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [WORD_W-1:0]   result_q, result_d;

    logic [WORD_W-1:0]   a_mag, b_mag;
    logic                neg_in;
    logic                accept;
    logic [SW-1:0]       shift;
    logic [2*WORD_W-1:0] step_acc;
    logic [2*WORD_W-1:0] product;

    // Operand magnitudes; the most negative value negates to itself, which is its correct unsigned magnitude
    always_comb begin
        a_mag  = (signed_a && opa[MSB]) ? -opa : opa;
        b_mag  = (signed_b && opb[MSB]) ? -opb : opb;
        neg_in = (signed_a & opa[MSB]) ^ (signed_b & opb[MSB]);
        accept = start && !flush && (state_q == IDLE || state_q == DONE);
        shift  = SW'((ITER - 1 - int'(cnt_q)) * BITS_PER_CYCLE);
    end

    mult_step #(
        .WORD_W         (WORD_W),
        .BITS_PER_CYCLE (BITS_PER_CYCLE),
        .SH_W           (SW)
    ) u_step (
        .acc_i   (acc_q),
        .a_i     (a_q),
        .chunk_i (b_q[BITS_PER_CYCLE-1:0]),
        .shift_i (shift),
        .acc_o   (step_acc)
    );

    // Sign correction happens once, on the final accumulator value entering DONE
    always_comb product = neg_q ? -step_acc : step_acc;

    // Next-state logic: accept in IDLE/DONE, iterate in BUSY, flush drops back to IDLE
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        neg_d    = neg_q;
        half_d   = half_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (accept) begin
            state_d = BUSY;
            a_d     = a_mag;
            b_d     = b_mag;
            neg_d   = neg_in;
            half_d  = mult_half;
            acc_d   = '0;
            cnt_d   = CW'(ITER - 1);
        end else begin
            case (state_q)
                BUSY: begin
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        acc_d   = step_acc;
                        b_d     = b_q >> BITS_PER_CYCLE;
                        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
                        state_d = (cnt_q == '0) ? DONE : BUSY;
                        if (cnt_q == '0)
                            result_d = half_q ? product[2*WORD_W-1:WORD_W] : product[WORD_W-1:0];
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            half_q   <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            half_q   <= half_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Status decodes straight from the state register
    always_comb begin
        busy   = (state_q == BUSY);
        done   = (state_q == DONE);
        result = result_q;
    end

endmodule
